// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run-control: button conditioning, run/pause/lap FSM, seconds prescaler
// Define STOPWATCH_LAP_EN to enable the lap button, LAP state, lap_load and freeze.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10_000_000,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       tick,
  output logic       count_clr,
  output logic       lap_load,
  output logic       freeze,
  output logic [1:0] state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_LAP   = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE - 1);

  // Button vector order: clear, stop, start, then lap when enabled.
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 4;
  logic [NB-1:0] btn_raw;
  assign btn_raw = {btn_lap, btn_start, btn_stop, btn_clear};
`else
  localparam int NB = 3;
  logic [NB-1:0] btn_raw;
  logic          unused_lap;
  assign btn_raw    = {btn_start, btn_stop, btn_clear};
  assign unused_lap = btn_lap;
`endif

  logic [NB-1:0] sync1, sync2, db, db_d, press;
  logic [CW-1:0] db_cnt [NB];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      press <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_d  <= db;
      press <= db & ~db_d;
      // Level flips only after DEBOUNCE consecutive disagreeing samples.
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic clr_p, stop_p, start_p, lap_p;
  assign clr_p   = press[0];
  assign stop_p  = press[1];
  assign start_p = press[2];
`ifdef STOPWATCH_LAP_EN
  assign lap_p   = press[3];
`else
  assign lap_p   = 1'b0;
`endif

  logic [1:0]    state_next;
  logic [PW-1:0] presc;
  logic          timing;
  logic          tick_next, count_clr_next, lap_load_next, freeze_next;

  assign timing = (state == S_RUN) || (state == S_LAP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Per state, the first valid strobe in clear > stop > start > lap order wins.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (clr_p)        state_next = S_IDLE;
        else if (start_p) state_next = S_RUN;
      end
      S_RUN: begin
        if (clr_p)        state_next = S_IDLE;
        else if (stop_p)  state_next = S_PAUSE;
        else if (lap_p)   state_next = S_LAP;
      end
      S_PAUSE: begin
        if (clr_p)        state_next = S_IDLE;
        else if (start_p) state_next = S_RUN;
      end
      default: begin
        if (clr_p)        state_next = S_IDLE;
        else if (stop_p)  state_next = S_PAUSE;
        else if (lap_p)   state_next = S_RUN;
      end
    endcase
  end

  always_comb begin
    tick_next      = timing && (presc == PRESC_MAX);
    count_clr_next = clr_p;
`ifdef STOPWATCH_LAP_EN
    lap_load_next  = (state == S_RUN) && lap_p && !clr_p && !stop_p;
    freeze_next    = (state_next == S_LAP);
`else
    lap_load_next  = 1'b0;
    freeze_next    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= 1'b0;
      count_clr <= 1'b0;
      lap_load  <= 1'b0;
      freeze    <= 1'b0;
    end else begin
      tick      <= tick_next;
      count_clr <= count_clr_next;
      lap_load  <= lap_load_next;
      freeze    <= freeze_next;
    end
  end

  // Holds while paused so the partial second survives a stop/start.
  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      presc <= '0;
    end else if (timing) begin
      if (presc == PRESC_MAX) presc <= '0;
      else                    presc <= presc + 1'b1;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed and randomized bench for stopwatch_ctrl against a transition-table model
module tb_stopwatch_ctrl;

  localparam int TD  = 10;
  localparam int DB  = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, btn_start, btn_stop, btn_lap, btn_clear;
  logic tick, count_clr, lap_load, freeze;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .tick(tick), .count_clr(count_clr), .lap_load(lap_load), .freeze(freeze), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_tick = 0;

  // Reference model: events 0=clear 1=stop 2=start 3=lap; -1 means ignored.
  int dest_tbl [4][4] = '{'{0, -1, 1, -1}, '{0, 2, -1, 3}, '{0, -1, 1, -1}, '{0, 2, -1, 1}};
  int h1 [4], h2 [4], lvl [4], run_c [4], act_edge [4];
  int m_state, elapsed, edge_n;
  bit m_tick, m_clr, m_lapld, m_freeze;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      h1[b] = 0; h2[b] = 0; lvl[b] = 0; run_c[b] = 0; act_edge[b] = -1;
    end
    m_state = 0; elapsed = 0;
    m_tick = 0; m_clr = 0; m_lapld = 0; m_freeze = 0;
  endtask

  task automatic model_step();
    int raw [4];
    bit pr [4];
    int sync, nxt;
    raw[0] = int'(btn_clear); raw[1] = int'(btn_stop);
    raw[2] = int'(btn_start); raw[3] = LAP_EN ? int'(btn_lap) : 0;
    edge_n++;
    if (rst) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 4; b++) begin
      pr[b] = (act_edge[b] == edge_n);
      sync = h2[b]; h2[b] = h1[b]; h1[b] = raw[b];
      if (sync != lvl[b]) begin
        run_c[b]++;
        if (run_c[b] == DB) begin
          lvl[b] = sync; run_c[b] = 0;
          if (sync == 1) act_edge[b] = edge_n + 2;
        end
      end else begin
        run_c[b] = 0;
      end
    end
    if (m_state == 1 || m_state == 3) begin
      elapsed++;
      m_tick = (elapsed % TD) == 0;
    end else begin
      if (m_state == 0) elapsed = 0;
      m_tick = 0;
    end
    nxt = m_state; m_clr = 0; m_lapld = 0;
    for (int e = 0; e < 4; e++) begin
      if (pr[e] && dest_tbl[m_state][e] >= 0) begin
        nxt = dest_tbl[m_state][e];
        m_clr = (e == 0);
        m_lapld = (e == 3) && (m_state == 1);
        break;
      end
    end
    m_state = nxt;
    m_freeze = (nxt == 3);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    if (tick === 1'b1) n_tick++;
    check("state", state, m_state);
    check("tick", tick, m_tick);
    check("count_clr", count_clr, m_clr);
    check("lap_load", lap_load, m_lapld);
    check("freeze", freeze, m_freeze);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int t0, lvl_b, len;
    logic [31:0] rnd;
    edge_n = 0;
    model_reset();
    rst = 1'b1; btn_start = 0; btn_stop = 0; btn_lap = 0; btn_clear = 0;
    run(2);
    check("rst_state", state, 0);
    check("rst_tick", tick, 0);
    check("rst_freeze", freeze, 0);
    rst = 1'b0;
    run(3);

    // Bounce shorter than the debounce window never registers.
    t0 = 0; lvl_b = 0;
    while (t0 < 40) begin
      len = $urandom_range(1, 3);
      btn_start = lvl_b[0];
      run(len);
      t0 += len;
      lvl_b = 1 - lvl_b;
    end
    btn_start = 0;
    run(8);
    check("bounce_state", state, 0);

    // Start: state at k+7, first tick at k+17; stop lands at entry+13.
    btn_start = 1;
    run(7);
    check("start_pre", state, 0);
    run(1);
    check("start_post", state, 1);
    btn_start = 0;
    run(5);
    btn_stop = 1;
    run(4);
    check("first_tick_pre", tick, 0);
    run(1);
    check("first_tick", tick, 1);
    run(3);
    check("stop_state", state, 2);
    check("stop_tick", tick, 0);
    btn_stop = 0;
    t0 = n_tick;
    run(12);
    check("paused_ticks", n_tick - t0, 0);

    // Resume: prescaler held at 3, so the tick comes 7 cycles after re-entry.
    btn_start = 1;
    run(7);
    check("resume_pre", state, 2);
    run(1);
    check("resume_post", state, 1);
    btn_start = 0;
    run(6);
    check("resume_tick_pre", tick, 0);
    run(1);
    check("resume_tick", tick, 1);

    // Clear and start together: clear wins.
    btn_clear = 1; btn_start = 1;
    run(8);
    check("clr_state", state, 0);
    check("clr_pulse", count_clr, 1);
    btn_clear = 0; btn_start = 0;
    run(1);
    check("clr_single", count_clr, 0);
    t0 = n_tick;
    run(20);
    check("idle_ticks", n_tick - t0, 0);

    // Lap enter, ticks continue, lap exit, lap again, reset in LAP.
    btn_start = 1;
    run(8);
    check("lap_run", state, 1);
    btn_start = 0;
    run(10);
    btn_lap = 1;
    run(8);
    check("lap_state", state, LAP_EN ? 3 : 1);
    check("lap_load", lap_load, LAP_EN ? 1 : 0);
    check("lap_freeze", freeze, LAP_EN ? 1 : 0);
    run(1);
    check("lap_load_single", lap_load, 0);
    t0 = n_tick;
    run(20);
    check("lap_ticks", n_tick - t0, 2);
    btn_lap = 0;
    run(6);
    btn_lap = 1;
    run(8);
    check("unlap_state", state, 1);
    check("unlap_freeze", freeze, 0);
    btn_lap = 0;
    run(6);
    btn_lap = 1;
    run(8);
    check("relap_freeze", freeze, LAP_EN ? 1 : 0);
    btn_lap = 0;
    rst = 1;
    run(1);
    rst = 0;
    check("rst_lap_state", state, 0);
    check("rst_lap_freeze", freeze, 0);
    check("rst_lap_tick", tick, 0);
    check("rst_lap_clr", count_clr, 0);
    check("rst_lap_load", lap_load, 0);

    // Button held through reset is accepted after the normal latency.
    btn_start = 1;
    rst = 1;
    run(3);
    rst = 0;
    run(7);
    check("held_rst_pre", state, 0);
    run(1);
    check("held_rst_post", state, 1);
    btn_start = 0;
    run(6);

    // Randomized segments, checked every cycle against the model.
    for (int seg = 0; seg < 300; seg++) begin
      rnd = $urandom;
      btn_clear = (rnd[2:0] == 3'd0);
      btn_stop  = (rnd[4:3] == 2'd0);
      btn_start = (rnd[6:5] != 2'd0) && rnd[7];
      btn_lap   = (rnd[9:8] != 2'd0) && rnd[10];
      if (rnd[16:11] == 6'd0) begin
        rst = 1;
        run(1);
        rst = 0;
      end
      run($urandom_range(1, 12));
    end
    btn_clear = 0; btn_stop = 0; btn_start = 0; btn_lap = 0;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run-control sequencer for the stopwatch datapath. It conditions four raw push-buttons (start, stop, lap, clear) and runs a small state machine. It also divides the system clock into a seconds tick. The stopwatch counter consumes `tick` and `count_clr`, and the display path consumes `freeze` and `lap_load`. The counter itself never sees raw button inputs.

## Interface
Parameters:
- `TICK_DIV`, 10_000_000: clock cycles per `tick`, ≥2.
- `DEBOUNCE`, 16: consecutive stable cycles required to accept a button level change, ≥1.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  raw start button, asynchronous to `clk`.
- `btn_stop`  in  1  raw stop button.
- `btn_lap`  in  1  raw lap button.
- `btn_clear`  in  1  raw clear button.
- `tick`  out  1  one-cycle pulse every `TICK_DIV` cycles while timing.
- `count_clr`  out  1  one-cycle pulse; clears the stopwatch counter.
- `lap_load`  out  1  one-cycle pulse; capture the current time into the lap register.
- `freeze`  out  1  level; display shows the lap register instead of the live time.
- `state`  out  2  0=IDLE, 1=RUNNING, 2=PAUSED, 3=LAP.

## Operation
- **Input conditioning (per button):**
  - A 2-flop synchronizer feeds a debouncer.
  - The debounced level flips only after the synchronized input has differed from it for `DEBOUNCE` consecutive cycles. Any agreeing cycle zeroes the debounce counter.
  - A rising edge of the debounced level produces a one-cycle press strobe.
- **Priority:** if several strobes occur in the same cycle, clear > stop > start > lap. Only the highest-priority strobe that is valid in the current state acts; the others are dropped.
- **FSM:**
  - IDLE:
    - start → RUNNING.
    - clear → pulse `count_clr`, stay in IDLE.
    - stop and lap are ignored.
  - RUNNING:
    - stop → PAUSED.
    - lap → LAP, with a `lap_load` pulse.
    - clear → IDLE, with a `count_clr` pulse.
    - start is ignored.
  - PAUSED:
    - start → RUNNING.
    - clear → IDLE, with a `count_clr` pulse.
    - lap is ignored.
  - LAP:
    - lap → RUNNING.
    - stop → PAUSED.
    - clear → IDLE, with a `count_clr` pulse.
    - start is ignored.
- **Prescaler:** counter of width `$clog2(TICK_DIV)`.
  - Increments in RUNNING and LAP, and wraps from `TICK_DIV-1` to 0. The wrap cycle asserts `tick`.
  - Holds its value in PAUSED, so the partial second is preserved.
  - Is forced to 0 in IDLE.
- **freeze:** 1 exactly while `state`==LAP. Timing and `tick` continue during LAP.

## Timing
- All outputs are registered.
- Reset values: `tick`=0, `count_clr`=0, `lap_load`=0, `freeze`=0, `state`=IDLE. Synchronizers, debounced levels, debounce counters and prescaler also reset to 0.
- Press latency: raw button first sampled high at edge k → `state`, `count_clr` and `lap_load` update at edge k+`DEBOUNCE`+3.
- First `tick` comes `TICK_DIV` cycles after entry into RUNNING from IDLE. After resuming from PAUSED, it comes after `TICK_DIV` minus the held prescaler count.
- Strobe pulses are exactly one cycle, even if a button is held indefinitely. A held button produces no repeats.
- A press accepted on the same edge as a prescaler wrap still gets that `tick`.
  - Stop at the wrap: the tick is emitted and the prescaler holds at 0.
  - Clear at the wrap: the tick is emitted together with `count_clr`, and the counter gives clear priority.
- Reset mid-operation: `rst` sampled high at edge e → all outputs at reset values after edge e, with no trailing pulses.
- A button held through reset is registered as a press once `rst` falls, after the normal latency.

## Configuration
- `STOPWATCH_LAP_EN` defined: lap behaviour as specified above.
- `STOPWATCH_LAP_EN` undefined:
  - `btn_lap` is ignored and needs no synchronizer.
  - The LAP state is unreachable.
  - `lap_load` and `freeze` are tied to 0.
  - All other behaviour and timing are identical.

## Test plan
All tests use `DEBOUNCE`=4 and `TICK_DIV`=10.
- Reset, then hold `btn_start` for 8 cycles from edge k → `state`=1 at edge k+7. First `tick` at k+17, then every 10 cycles. Exactly one transition.
- Bounce: `btn_start` toggled with high and low runs of ≤3 cycles for 40 cycles → `state` stays 0 and no pulses occur.
- RUNNING for 13 cycles after entry (3 cycles past the first tick), then stop → `state`=2 and no `tick`. Then start → next `tick` exactly 7 cycles after `state` returns to 1.
- In RUNNING, press `btn_clear` and `btn_start` simultaneously → `state`=0 and one `count_clr` pulse. Prescaler is 0, and no `tick` follows.
- Lap, with the macro defined:
  - In RUNNING, press lap → one `lap_load` pulse, `freeze`=1 and `state`=3, with ticks continuing.
  - Press lap again → `freeze`=0 and `state`=1.
  - With the macro undefined, the same stimulus → no change.
- Assert `rst` for one cycle while in LAP with `freeze`=1 → next cycle all outputs are 0 and `state`=0.
